// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer:
// data width, ALU control encodings and the sequencer state enumeration.
package mult_sequencer_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;
  localparam logic [2:0] ALU_SRL = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHL,
    ST_SHR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mult_sequencer_if.sv
// Request/response and shared-ALU signals between the EX-stage parent (master)
// and the multiply sequencer (slave).
interface mult_sequencer_if;
  import mult_sequencer_pkg::*;

  logic              start;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [4:0]        alu_shamt;
  logic              alu_own;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] product;

  modport master (
    output start, op_a, op_b, alu_result,
    input  alu_ctrl, alu_src1, alu_src2, alu_shamt, alu_own, busy, done, product
  );

  modport slave (
    input  start, op_a, op_b, alu_result,
    output alu_ctrl, alu_src1, alu_src2, alu_shamt, alu_own, busy, done, product
  );

endinterface

// File: rtl/mult_sequencer.sv
// Shift-add multiplier that borrows the parent's ALU for every add and shift:
// ADD (conditional accumulate) -> SHL (mcand<<1) -> SHR (mplier>>1), until mplier is 0.
module mult_sequencer
  import mult_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mult_sequencer_if.slave   bus
);

  state_e            state_q,   state_d;
  logic [DATA_W-1:0] acc_q,     acc_d;
  logic [DATA_W-1:0] mcand_q,   mcand_d;
  logic [DATA_W-1:0] mplier_q,  mplier_d;
  logic [DATA_W-1:0] product_q, product_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        // Exhausted multiplier: finish without touching the ALU.
        if (mplier_q == '0) begin
          product_d = acc_q;
          state_d   = ST_DONE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = bus.alu_result;
          end
          state_d = ST_SHL;
        end
      end
      ST_SHL: begin
        mcand_d = bus.alu_result;
        state_d = ST_SHR;
      end
      ST_SHR: begin
        mplier_d = bus.alu_result;
        state_d  = ST_ADD;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.alu_ctrl  = ALU_AND;
    bus.alu_src1  = '0;
    bus.alu_src2  = '0;
    bus.alu_shamt = '0;
    bus.alu_own   = 1'b0;
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = (state_q == ST_DONE);
    bus.product   = product_q;
    case (state_q)
      ST_ADD: begin
        if (mplier_q != '0) begin
          bus.alu_own  = 1'b1;
          bus.alu_ctrl = ALU_ADD;
          bus.alu_src1 = acc_q;
          bus.alu_src2 = mcand_q;
        end
      end
      ST_SHL: begin
        bus.alu_own   = 1'b1;
        bus.alu_ctrl  = ALU_SLL;
        bus.alu_src1  = mcand_q;
        bus.alu_shamt = 5'd1;
      end
      ST_SHR: begin
        bus.alu_own   = 1'b1;
        bus.alu_ctrl  = ALU_SRL;
        bus.alu_src1  = mplier_q;
        bus.alu_shamt = 5'd1;
      end
      default: begin
        bus.alu_own = 1'b0;
      end
    endcase
  end

endmodule
